// File: rtl/rng_arbiter.sv
// Random-word arbiter: starts a random-number generator, takes its words
// through a one-entry holding buffer and hands each word to exactly one
// requester, rotating round-robin over the active requests.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | generator stopped; buffered word (if any) still drains
// ST_START| one-cycle start pulse towards the generator
// ST_RUN  | generator words accepted whenever the buffer can take one
module rng_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic              rng_start,
  input  logic [DATA_W-1:0] rng_data,
  input  logic              rng_valid,
  output logic              rng_ready,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [DATA_W-1:0] rand_data,
  output logic [31:0]       served_count,
  output logic              busy
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]  buf_data_q, buf_data_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  rand_data_q, rand_data_d;
  logic [31:0]        served_q, served_d;

  logic               consume;
  logic               xfer;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int                 cand;

  // The buffer drains in any state, so consumption does not look at the FSM.
  assign consume   = buf_valid_q & (|req);
  assign rng_ready = (state_q == ST_RUN) & (~buf_valid_q | consume);
  assign xfer      = rng_valid & rng_ready;

  assign rng_start    = (state_q == ST_START);
  assign busy         = (state_q == ST_RUN);
  assign grant        = grant_q;
  assign rand_data    = rand_data_q;
  assign served_count = served_q;

  // Round-robin search: first active request at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state logic for the FSM, holding buffer, grant and counters.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = '0;
    rand_data_d = rand_data_q;
    served_d    = served_q;

    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (consume) begin
      grant_d[win_idx] = 1'b1;
      rand_data_d      = buf_data_q;
      served_d         = served_q + 32'd1;
      if (win_idx == PTR_W'(N_REQ - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = win_idx + PTR_W'(1);
      buf_valid_d      = 1'b0;
    end

    // A same-cycle transfer refills the slot just freed, sustaining one grant per cycle.
    if (xfer) begin
      buf_valid_d = 1'b1;
      buf_data_d  = rng_data;
    end
  end

  // State registers; reset discards any buffered word and pending grant.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      rand_data_q <= '0;
      served_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      rand_data_q <= rand_data_d;
      served_q    <= served_d;
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: generator words are queued when the
// handshake completes and popped when the reference model expects a grant.
module tb_rng_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        enable;
  logic        rng_start;
  logic [31:0] rng_data;
  logic        rng_valid;
  logic        rng_ready;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [31:0] rand_data;
  logic [31:0] served_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // reference model
  int          m_state;   // 0 idle, 1 start, 2 run
  int          m_rr;
  logic [31:0] m_cnt;
  logic [31:0] m_last;
  logic [31:0] sb_q[$];

  rng_arbiter #(.N_REQ(N), .DATA_W(32)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .rng_start(rng_start),
    .rng_data(rng_data), .rng_valid(rng_valid), .rng_ready(rng_ready),
    .req(req), .grant(grant), .rand_data(rand_data),
    .served_count(served_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    m_state = 0; m_rr = 0; m_cnt = 0; m_last = 0;
    sb_q.delete();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_data",  rand_data, 32'd0);
    chk("rst_count", served_count, 32'd0);
    chk("rst_start", 32'(rng_start), 32'd0);
    chk("rst_ready", 32'(rng_ready), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    resetn = 1'b1;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic step();
    logic bv, consume, exp_ready;
    logic [N-1:0] eg;
    int w;
    #3;
    bv        = (sb_q.size() != 0);
    consume   = bv && (req != 0);
    exp_ready = (m_state == 2) && (!bv || consume);
    chk("ready", 32'(rng_ready), 32'(exp_ready));
    chk("start", 32'(rng_start), 32'(m_state == 1));
    chk("busy",  32'(busy), 32'(m_state == 2));
    eg = '0;
    if (consume) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
      eg[w]  = 1'b1;
      m_last = sb_q.pop_front();
      m_rr   = (w + 1) % N;
      m_cnt  = m_cnt + 32'd1;
    end
    if (rng_valid && exp_ready) sb_q.push_back(rng_data);
    case (m_state)
      0: if (enable) m_state = 1;
      1: m_state = 2;
      default: if (!enable) m_state = 0;
    endcase
    @(posedge clock);
    #1;
    chk("grant", 32'(grant), 32'(eg));
    chk("data",  rand_data, m_last);
    chk("count", served_count, m_cnt);
  endtask

  initial begin
    enable = 0; rng_data = 0; rng_valid = 0; req = 0; resetn = 0;
    do_reset();

    // start pulse then busy
    enable = 1;
    step();                 // IDLE -> START
    step();                 // START pulse seen
    step();                 // RUN, busy
    chk("busy_run", 32'(busy), 32'd1);

    // single requester, fixed word
    req = 4'b0001; rng_valid = 1; rng_data = 32'hA5A5A5A5;
    step();
    rng_valid = 0;
    step();
    chk("a5_grant", 32'(grant), 32'h1);
    chk("a5_data", rand_data, 32'hA5A5A5A5);
    chk("a5_count", served_count, 32'd1);
    req = 0;
    step();

    // all requesting, generator always valid: rotation 0001..1000,0001
    do_reset();
    enable = 1; step(); step();
    req = 4'b1111; rng_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rng_data = $urandom;
      step();
    end
    rng_valid = 0; req = 0; step();

    // rr_ptr = 2 then req=1010 -> 1000 then 0010
    do_reset();
    enable = 1; step(); step();
    req = 4'b0010; rng_valid = 1; rng_data = 32'h1111_0001;
    step();
    rng_data = 32'h2222_0002; req = 4'b1010;
    step();                 // grant 0010 -> rr=2
    rng_data = 32'h3333_0003;
    step();
    chk("rr2_first", 32'(grant), 32'h8);
    rng_valid = 0;
    step();
    chk("rr2_next", 32'(grant), 32'h2);
    req = 0; step();

    // no requests: ready drops after one word, then requester 2 gets it
    rng_valid = 1; rng_data = 32'hCAFE_0042;
    step();
    rng_data = 32'hDEAD_BEEF;
    step();
    chk("hold_ready", 32'(rng_ready), 32'd0);
    step();
    rng_valid = 0; req = 4'b0100;
    step();
    chk("hold_grant", 32'(grant), 32'h4);
    chk("hold_data", rand_data, 32'hCAFE_0042);
    req = 0; step();

    // drain after enable drops, plus counter wrap
    rng_valid = 1; rng_data = 32'h0BAD_F00D;
    step();
    rng_valid = 0; enable = 0;
    step();                 // RUN -> IDLE
    step();
    chk("drain_ready", 32'(rng_ready), 32'd0);
    force dut.served_q = 32'hFFFF_FFFF;
    #1;
    release dut.served_q;
    m_cnt = 32'hFFFF_FFFF;
    req = 4'b0001;
    step();
    chk("drain_grant", 32'(grant), 32'h1);
    chk("wrap_count", served_count, 32'd0);
    step();
    chk("drain_once", 32'(grant), 32'h0);
    req = 0;

    // reset mid-operation drops the buffered word
    enable = 1; step(); step();
    rng_valid = 1; rng_data = 32'h5555_AAAA;
    step();
    rng_valid = 0;
    do_reset();
    req = 4'b1111;
    step();
    chk("post_rst_grant", 32'(grant), 32'h0);
    req = 0;

    // random traffic
    for (int i = 0; i < 300; i++) begin
      req       = N'($urandom);
      rng_valid = 1'($urandom_range(0, 1));
      rng_data  = $urandom;
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 The block SHALL expose parameter N_REQ, default 4, meaning the number of requesters sharing one random-number stream (legal range 2..16).
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning the random-word width.
REQ-003 clock  in  1  single clock; all logic is rising-edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  level; high = stream random words from the generator.
REQ-006 rng_start  out  1  one-cycle start pulse to the generator call.enable.
REQ-007 rng_data  in  DATA_W  generator word.
REQ-008 rng_valid  in  1  generator word valid.
REQ-009 rng_ready  out  1  arbiter accepts generator word.
REQ-010 req  in  N_REQ  per-requester level request for one word per grant.
REQ-011 grant  out  N_REQ  registered one-hot pulse; bit i = rand_data is for requester i this cycle.
REQ-012 rand_data  out  DATA_W  registered word accompanying grant.
REQ-013 served_count  out  32  total words granted since reset.
REQ-014 busy  out  1  high in state RUN.

Function
REQ-015 FSM states SHALL be IDLE, START, RUN; reset state IDLE.
REQ-016 IDLE -> START on enable=1; START -> RUN unconditionally after 1 cycle; RUN -> IDLE when enable=0; START with enable=0 still goes to RUN for one cycle, then IDLE.
REQ-017 rng_start SHALL be 1 exactly during START, 0 otherwise; each re-entry to START issues a new pulse.
REQ-018 A one-entry holding buffer (buf_valid, buf_data) SHALL store accepted generator words.
REQ-019 rng_ready SHALL be 1 only in RUN and only when buf_valid=0 or the buffer is consumed this cycle (combinational from registered state and req).
REQ-020 A word transfers when rng_valid=1 and rng_ready=1; buffer loads on the next edge.
REQ-021 Buffer is consumed in a cycle when buf_valid=1 and |req=1, in any state (words remaining after enable drops still drain).
REQ-022 On consume, winner i = first set req bit at or after rr_ptr, searching upward modulo N_REQ; next edge: grant=one-hot(i), rand_data=buf_data, rr_ptr=(i+1) mod N_REQ.
REQ-023 If no consume, grant SHALL be 0 next cycle and rand_data SHALL hold its previous value.
REQ-024 Simultaneous consume and generator transfer SHALL leave buf_valid=1 with the new word (one grant per cycle sustained).
REQ-025 Word latency: generator transfer at edge t, grant earliest at edge t+1 (buffer loaded at t, consumed during cycle t..t+1).
REQ-026 Each generator word SHALL be granted exactly once; no word duplicated or dropped.
REQ-027 served_count SHALL increment by 1 per grant pulse, wrapping 0xFFFFFFFF -> 0.
REQ-028 Requesters may drop req at any time; grant is a pulse needing no acknowledgment.

Reset
REQ-029 With resetn=0 at an edge: state=IDLE, buf_valid=0, rr_ptr=0, grant=0, rand_data=0, served_count=0, rng_start=0, rng_ready=0, busy=0.
REQ-030 Reset mid-operation SHALL discard the buffered word and any pending grant; reset dominates all other inputs.

Verification
REQ-031 Reset then enable=1 -> rng_start=1 for exactly one cycle, busy=1 from the following cycle.
REQ-032 RUN, req=4'b0001, generator supplies 0xA5A5A5A5 -> grant=4'b0001 with rand_data=0xA5A5A5A5 one cycle after buffer load; served_count=1.
REQ-033 RUN, req=4'b1111 held, generator always valid -> grants cycle 0001,0010,0100,1000,0001 on consecutive cycles, one per cycle.
REQ-034 req=4'b1010, rr_ptr=2 -> first grant 1000, next 0010.
REQ-035 RUN, req=0, generator valid -> rng_ready drops after one word, buffer holds it; then req=4'b0100 -> grant=0100 with that word, no word lost.
REQ-036 enable low with buf_valid=1 and req=0001 -> state IDLE, rng_ready=0, grant 0001 still issued once; served_count preset to 0xFFFFFFFF then one grant -> 0.
